// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes and opcodes.
// States StAddiEx/StAddiWb exist only when ADDI_EN is defined.
package mips_pkg;

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecute = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
`ifdef ADDI_EN
      StJump    = 4'd9,
      StAddiEx  = 4'd10,
      StAddiWb  = 4'd11
`else
      StJump    = 4'd9
`endif
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM; outputs decoded from state (and mem_ready).
// Define ADDI_EN to add the addi path (StAddiEx -> StAddiWb).
module multicycle_control
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic       ALUSrcA,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUOp1,
   output logic       ALUOp0,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic       illegal_op,
   output logic       instr_done
);

   state_e     state_q, state_d;
   logic [1:0] alu_op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StFetch;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      alu_op      = ALU_ADD;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;

      case (state_q)
         StFetch: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = mem_ready;
            IRWrite = mem_ready;
            if (mem_ready) state_d = StDecode;
         end
         StDecode: begin
            ALUSrcB = 2'b11;
            case (Op)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StExecute;
               OP_BEQ:       state_d = StBranch;
               OP_J:         state_d = StJump;
`ifdef ADDI_EN
               OP_ADDI:      state_d = StAddiEx;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StMemAdr: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (Op == OP_LW)      state_d = StMemRd;
            else if (Op == OP_SW) state_d = StMemWr;
            else                  state_d = StFetch;
         end
         StMemRd: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = StMemWb;
         end
         StMemWb: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StMemWr: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_d = StFetch;
         end
         StExecute: begin
            ALUSrcA = 1'b1;
            alu_op  = ALU_FUNCT;
            state_d = StAluWb;
         end
         StAluWb: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StBranch: begin
            ALUSrcA     = 1'b1;
            alu_op      = ALU_SUB;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            instr_done  = 1'b1;
            state_d     = StFetch;
         end
         StJump: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
`ifdef ADDI_EN
         StAddiEx: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
`endif
         default: state_d = StFetch;
      endcase

      // State is already StFetch during reset; suppress the mem_ready-driven writes too.
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
         illegal_op  = 1'b0;
         instr_done  = 1'b0;
      end
   end

   assign {ALUOp1, ALUOp0} = alu_op;

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and reset are the first two ports.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Op  in  6  opcode field of the instruction register.
REQ-005 mem_ready  in  1  memory handshake; 1 = current access completes this cycle.
REQ-006 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
REQ-007 ALUOp1, ALUOp0  out  1 each  ALU control encoding: 00 add, 01 sub, 10 use funct.
REQ-008 ALUSrcB  out  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-010 illegal_op  out  1  one-cycle pulse on an unsupported opcode.
REQ-011 instr_done  out  1  one-cycle pulse in the final state of each instruction.

Function
REQ-012 The state register SHALL be 4 bits: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; codes 12-15 SHALL go to FETCH.
REQ-013 Outputs SHALL be decoded combinationally from the state, plus mem_ready where stated; every control not listed for a state SHALL be 0.
REQ-014 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=IRWrite=mem_ready; it SHALL hold while mem_ready=0 and advance to DECODE when mem_ready=1.
REQ-015 DECODE: ALUSrcB=11, ALUOp=00; next state SHALL be 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 000010->JUMP, 001000->ADDIEX (when enabled).
REQ-016 An opcode not listed in REQ-015 SHALL cause DECODE->FETCH with illegal_op=1 for that cycle.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state SHALL be MEMRD for 100011 and MEMWR for 101011.
REQ-018 MEMRD: MemRead=1, IorD=1; it SHALL hold until mem_ready=1, then go to MEMWB.
REQ-019 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; next state FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; it SHALL hold until mem_ready=1, then go to FETCH with instr_done=1 in the completing cycle.
REQ-021 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-022 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1; next state FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; next state FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10, instr_done=1; next state FETCH.
REQ-025 Instruction latency with mem_ready tied to 1 SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-026 MemRead and MemWrite SHALL never be 1 in the same cycle.

Reset
REQ-027 Reset SHALL force state=FETCH immediately, independent of clk.
REQ-028 While reset=1, PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, illegal_op and instr_done SHALL be 0; the remaining outputs SHALL take their FETCH values.
REQ-029 Reset asserted in any state, including a wait in MEMRD or MEMWR, SHALL abort the instruction, and no write SHALL occur.

Configuration
REQ-030 With ADDI_EN defined, opcode 001000 SHALL use ADDIEX, then ADDIWB.
REQ-031 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-032 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, then go to FETCH.
REQ-033 Without ADDI_EN, states 10-11 SHALL not exist, and 001000 SHALL be illegal per REQ-016.

Structure
REQ-034 The state codes and opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI) SHALL live in the shared package mips_pkg.
REQ-035 No sub-module is required: the next-state logic and the output decode SHALL be inline in one module.

Verification
REQ-036 Reset mid-MEMRD with mem_ready=0 -> state=FETCH asynchronously, RegWrite=0, MemRead=1.
REQ-037 lw (100011) with mem_ready=1 -> states 0,1,2,3,4; RegWrite=MemtoReg=1 only in cycle 5; instr_done pulse in cycle 5.
REQ-038 R-type (000000) -> ALUOp=10 in EXECUTE; RegWrite=RegDst=1 in ALUWB; 4 cycles total.
REQ-039 sw with mem_ready=0 for 3 cycles in MEMWR -> MemWrite held for 4 cycles, then FETCH; PCWrite=0 throughout the wait.
REQ-040 Opcode 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; no write enables asserted.
REQ-041 addi (001000) -> 4-cycle completion with ADDI_EN defined; with it undefined -> illegal_op pulse.
